// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
// Module      : pc_fetch_ctrl
// Description : PC sequencer for the single-cycle core. Drives the PC
//               register load, handles the imem fetch handshake, holds the
//               fetched instruction until retire and picks the next PC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR    = 32'h0000_0004,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        pc_enable,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        retire,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        trap,
    input  logic        halt,
    input  logic        resume,
    output logic        fetch_fault,
    output logic [2:0]  state
);

    localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]        r_instr, w_instr_nxt;
    logic               r_instr_valid, w_instr_valid_nxt;
    logic [31:0]        w_redirect_pc;

    // Branch/jump targets are forced onto a word boundary.
    assign w_redirect_pc = redirect_target & ~32'h0000_0003;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_BOOT;
            r_cnt         <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = r_instr_valid;
        next_pc           = pc;
        pc_enable         = 1'b0;
        imem_req          = 1'b0;
        fetch_fault       = 1'b0;

        case (r_state)
            S_BOOT: begin
                pc_enable   = 1'b1;
                next_pc     = RESET_VECTOR;
                w_cnt_nxt   = '0;
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                // An ack on the last allowed cycle beats the timeout.
                if (imem_ack) begin
                    w_instr_nxt       = imem_rdata;
                    w_instr_valid_nxt = 1'b1;
                    w_cnt_nxt         = '0;
                    w_state_nxt       = S_EXEC;
                end else if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_FAULT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_EXEC: begin
                if (retire) begin
                    pc_enable         = 1'b1;
                    w_instr_valid_nxt = 1'b0;
                    if (trap)
                        next_pc = TRAP_VECTOR;
                    else if (redirect)
                        next_pc = w_redirect_pc;
                    else
                        next_pc = pc + 32'd4;
                    w_state_nxt = halt ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                if (resume)
                    w_state_nxt = S_FETCH;
            end
            S_FAULT: begin
                fetch_fault = 1'b1;
                pc_enable   = 1'b1;
                next_pc     = TRAP_VECTOR;
                w_state_nxt = S_FETCH;
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    assign imem_addr   = pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
// ============================================================================
// Module      : tb_pc_fetch_ctrl
// Description : Directed self-checking bench for pc_fetch_ctrl with a model
//               PC register closing the next_pc/pc_enable loop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_ctrl;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        pc_enable;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        retire;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        trap;
    logic        halt;
    logic        resume;
    logic        fetch_fault;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    pc_fetch_ctrl #(
        .RESET_VECTOR   (32'h0000_0100),
        .TRAP_VECTOR    (32'h0000_0004),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pc              (pc),
        .next_pc         (next_pc),
        .pc_enable       (pc_enable),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .retire          (retire),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .trap            (trap),
        .halt            (halt),
        .resume          (resume),
        .fetch_fault     (fetch_fault),
        .state           (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register model.
    initial pc = 32'h0;
    always @(posedge clk) if (pc_enable) pc <= next_pc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic clear_ctl();
        retire   = 1'b0;
        redirect = 1'b0;
        trap     = 1'b0;
        halt     = 1'b0;
        resume   = 1'b0;
        imem_ack = 1'b0;
        redirect_target = 32'h0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_ctl();
        imem_rdata = 32'h0;
        repeat (3) tick();
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", state); end
        n_cmp++; if (pc_enable !== 1'b1 || next_pc !== 32'h100) begin n_bad++; $display("FAIL rst_pc: en=%b next_pc=%h want en=1 next_pc=00000100", pc_enable, next_pc); end
        n_cmp++; if (imem_req !== 1'b0 || fetch_fault !== 1'b0) begin n_bad++; $display("FAIL rst_req: req=%b fault=%b want 0 0", imem_req, fetch_fault); end
        n_cmp++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr: valid=%b instr=%h want 0 0", instr_valid, instr); end
        reset_n = 1'b1;
        #1;
        n_cmp++; if (state !== 3'd0 || pc_enable !== 1'b1 || next_pc !== 32'h100) begin n_bad++; $display("FAIL boot_cycle0: state=%0d en=%b next_pc=%h want 0 1 00000100", state, pc_enable, next_pc); end
        tick();
        n_cmp++; if (state !== 3'd1 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_bad++; $display("FAIL boot_cycle1: state=%0d req=%b addr=%h want 1 1 00000100", state, imem_req, imem_addr); end
        n_cmp++; if (pc_enable !== 1'b0) begin n_bad++; $display("FAIL fetch_pc_en: got %b want 0", pc_enable); end
    endtask

    task automatic test_fetch_exec();
        do_fetch(32'h0050_0093);
        n_cmp++; if (state !== 3'd2 || instr_valid !== 1'b1 || instr !== 32'h0050_0093) begin n_bad++; $display("FAIL exec_entry: state=%0d valid=%b instr=%h want 2 1 00500093", state, instr_valid, instr); end
        tick();
        n_cmp++; if (instr !== 32'h0050_0093 || pc_enable !== 1'b0 || imem_req !== 1'b0) begin n_bad++; $display("FAIL exec_hold: instr=%h en=%b req=%b want 00500093 0 0", instr, pc_enable, imem_req); end
        retire = 1'b1;
        #1;
        n_cmp++; if (pc_enable !== 1'b1 || next_pc !== 32'h104) begin n_bad++; $display("FAIL seq_pc: en=%b next_pc=%h want 1 00000104", pc_enable, next_pc); end
        tick();
        clear_ctl();
        #1;
        n_cmp++; if (state !== 3'd1 || instr_valid !== 1'b0 || imem_addr !== 32'h104) begin n_bad++; $display("FAIL after_retire: state=%0d valid=%b addr=%h want 1 0 00000104", state, instr_valid, imem_addr); end
        // Walk up to the top of the address space and wrap.
        do_fetch(32'h1111_1111);
        retire = 1'b1; redirect = 1'b1; redirect_target = 32'hFFFF_FFFE;
        #1;
        n_cmp++; if (next_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL redirect_top: got %h want fffffffc", next_pc); end
        tick();
        clear_ctl();
        #1;
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL fetch_top: got %h want fffffffc", imem_addr); end
        do_fetch(32'h2222_2222);
        retire = 1'b1;
        #1;
        n_cmp++; if (next_pc !== 32'h0 || pc_enable !== 1'b1) begin n_bad++; $display("FAIL wrap_pc: next_pc=%h en=%b want 00000000 1", next_pc, pc_enable); end
        tick();
        clear_ctl();
        #1;
        n_cmp++; if (state !== 3'd1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_fetch: state=%0d addr=%h want 1 00000000", state, imem_addr); end
    endtask

    task automatic test_redirect();
        do_fetch(32'h3333_3333);
        redirect = 1'b1; trap = 1'b1; halt = 1'b1; redirect_target = 32'h203;
        #1;
        n_cmp++; if (pc_enable !== 1'b0) begin n_bad++; $display("FAIL no_retire_en: got %b want 0", pc_enable); end
        tick();
        n_cmp++; if (state !== 3'd2 || instr_valid !== 1'b1) begin n_bad++; $display("FAIL no_retire_state: state=%0d valid=%b want 2 1", state, instr_valid); end
        trap = 1'b0; halt = 1'b0;
        retire = 1'b1;
        #1;
        n_cmp++; if (next_pc !== 32'h200) begin n_bad++; $display("FAIL redirect_pc: got %h want 00000200", next_pc); end
        tick();
        clear_ctl();
        #1;
        n_cmp++; if (state !== 3'd1 || imem_addr !== 32'h200) begin n_bad++; $display("FAIL redirect_fetch: state=%0d addr=%h want 1 00000200", state, imem_addr); end
        do_fetch(32'h4444_4444);
        retire = 1'b1; trap = 1'b1; redirect = 1'b1; redirect_target = 32'h203;
        #1;
        n_cmp++; if (next_pc !== 32'h4) begin n_bad++; $display("FAIL trap_prio: got %h want 00000004", next_pc); end
        tick();
        clear_ctl();
        #1;
        n_cmp++; if (state !== 3'd1 || imem_addr !== 32'h4) begin n_bad++; $display("FAIL trap_fetch: state=%0d addr=%h want 1 00000004", state, imem_addr); end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (state !== 3'd1 || fetch_fault !== 1'b0) begin n_bad++; $display("FAIL to_wait%0d: state=%0d fault=%b want 1 0", i, state, fetch_fault); end
            tick();
        end
        n_cmp++; if (state !== 3'd4 || fetch_fault !== 1'b1) begin n_bad++; $display("FAIL to_fault: state=%0d fault=%b want 4 1", state, fetch_fault); end
        n_cmp++; if (pc_enable !== 1'b1 || next_pc !== 32'h4 || imem_req !== 1'b0) begin n_bad++; $display("FAIL to_trap_pc: en=%b next_pc=%h req=%b want 1 00000004 0", pc_enable, next_pc, imem_req); end
        tick();
        n_cmp++; if (state !== 3'd1 || fetch_fault !== 1'b0 || imem_addr !== 32'h4) begin n_bad++; $display("FAIL to_refetch: state=%0d fault=%b addr=%h want 1 0 00000004", state, fetch_fault, imem_addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (state !== 3'd1 || fetch_fault !== 1'b0) begin n_bad++; $display("FAIL late_wait%0d: state=%0d fault=%b want 1 0", i, state, fetch_fault); end
        end
        do_fetch(32'h5555_5555);
        n_cmp++; if (state !== 3'd2 || fetch_fault !== 1'b0 || instr !== 32'h5555_5555) begin n_bad++; $display("FAIL late_ack: state=%0d fault=%b instr=%h want 2 0 55555555", state, fetch_fault, instr); end
    endtask

    task automatic test_halt();
        retire = 1'b1; halt = 1'b1;
        #1;
        n_cmp++; if (next_pc !== 32'h8 || pc_enable !== 1'b1) begin n_bad++; $display("FAIL halt_commit: next_pc=%h en=%b want 00000008 1", next_pc, pc_enable); end
        tick();
        clear_ctl();
        #1;
        n_cmp++; if (state !== 3'd3 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL halt_enter: state=%0d valid=%b want 3 0", state, instr_valid); end
        for (int i = 0; i < 10; i++) begin
            imem_ack = i[0];
            retire   = ~i[0];
            #1;
            n_cmp++; if (state !== 3'd3 || imem_req !== 1'b0 || pc_enable !== 1'b0) begin n_bad++; $display("FAIL halt_hold%0d: state=%0d req=%b en=%b want 3 0 0", i, state, imem_req, pc_enable); end
            tick();
        end
        clear_ctl();
        resume = 1'b1;
        tick();
        resume = 1'b0;
        #1;
        n_cmp++; if (state !== 3'd1 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_bad++; $display("FAIL resume: state=%0d req=%b addr=%h want 1 1 00000008", state, imem_req, imem_addr); end
    endtask

    task automatic test_reset_mid_exec();
        do_fetch(32'h1234_5678);
        n_cmp++; if (state !== 3'd2 || instr !== 32'h1234_5678) begin n_bad++; $display("FAIL pre_reset: state=%0d instr=%h want 2 12345678", state, instr); end
        #1;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (state !== 3'd0 || instr_valid !== 1'b0 || instr !== 32'h0) begin n_bad++; $display("FAIL async_reset: state=%0d valid=%b instr=%h want 0 0 0", state, instr_valid, instr); end
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        n_cmp++; if (state !== 3'd0 || pc_enable !== 1'b1 || next_pc !== 32'h100) begin n_bad++; $display("FAIL reboot_cycle0: state=%0d en=%b next_pc=%h want 0 1 00000100", state, pc_enable, next_pc); end
        tick();
        n_cmp++; if (state !== 3'd1 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_bad++; $display("FAIL reboot_cycle1: state=%0d req=%b addr=%h want 1 1 00000100", state, imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_fetch_exec();
        test_redirect();
        test_timeout();
        test_halt();
        test_reset_mid_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
